// File: rtl/ram_pkg.sv
// Shared types and limits for the simple dual-port byte-enable RAM.
package ram_pkg;

  typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;

  localparam int MAX_OUT_REG_STAGES = 2;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_out_pipe.sv
// Valid-qualified output register chain; each data stage only loads when its
// incoming valid is set, so the tail keeps the last delivered word.
module ram_out_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_sync_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = i_clk ^ i_sync_rst_n;
    assign o_data    = i_data;
    assign o_valid   = i_valid;
  end else begin : g_pipe
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;

    always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
        valid_q <= '0;
        for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
      end else begin
        valid_q[0] <= i_valid;
        if (i_valid) data_q[0] <= i_data;
        for (int s = 1; s < STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end

    assign o_data  = data_q[STAGES-1];
    assign o_valid = valid_q[STAGES-1];
  end

endmodule

// File: rtl/ram_sdp_byte_en.sv
// Simple dual-port RAM with per-lane write enables, selectable same-address
// collision behaviour and an optional valid-qualified output pipeline.
module ram_sdp_byte_en import ram_pkg::*; #(
  parameter int        BYTE_BIT_WIDTH = 8,
  parameter int        BYTES_PER_WORD = 4,
  parameter int        DEPTH          = 16,
  parameter rdw_mode_e RDW_MODE       = RDW_WRITE_FIRST,
  parameter int        OUT_REG_STAGES = 1
) (
  input  logic                                     i_clk,
  input  logic                                     i_sync_rst_n,
  input  logic                                     i_we,
  input  logic [$clog2(DEPTH)-1:0]                 i_wr_addr,
  input  logic [BYTE_BIT_WIDTH*BYTES_PER_WORD-1:0] i_wr_data,
  input  logic [BYTES_PER_WORD-1:0]                i_wr_byte_en,
  input  logic                                     i_re,
  input  logic [$clog2(DEPTH)-1:0]                 i_rd_addr,
  output logic [BYTE_BIT_WIDTH*BYTES_PER_WORD-1:0] o_rd_data,
  output logic                                     o_rd_valid
);

  localparam int WORD_W = BYTE_BIT_WIDTH * BYTES_PER_WORD;

  if (!(BYTE_BIT_WIDTH == 8 || BYTE_BIT_WIDTH == 9)) begin : g_bad_byte_width
    $error("ram_sdp_byte_en: BYTE_BIT_WIDTH must be 8 or 9");
  end
  if (!is_pow2(BYTES_PER_WORD)) begin : g_bad_lanes
    $error("ram_sdp_byte_en: BYTES_PER_WORD must be a power of 2");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("ram_sdp_byte_en: DEPTH must be a power of 2 and at least 2");
  end
  if (OUT_REG_STAGES < 0 || OUT_REG_STAGES > MAX_OUT_REG_STAGES) begin : g_bad_stages
    $error("ram_sdp_byte_en: OUT_REG_STAGES out of range");
  end

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_word_d;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst_n && i_we) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (i_wr_byte_en[k])
          mem_q[i_wr_addr][k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH] <=
            i_wr_data[k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word_d = mem_q[i_rd_addr];
    if (RDW_MODE == RDW_WRITE_FIRST && i_we && (i_wr_addr == i_rd_addr)) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (i_wr_byte_en[k])
          rd_word_d[k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH] =
            i_wr_data[k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= i_re;
      if (i_re) rd_data_q <= rd_word_d;
    end
  end

  ram_out_pipe #(
    .WIDTH  (WORD_W),
    .STAGES (OUT_REG_STAGES)
  ) u_out_pipe (
    .i_clk        (i_clk),
    .i_sync_rst_n (i_sync_rst_n),
    .i_data       (rd_data_q),
    .i_valid      (rd_valid_q),
    .o_data       (o_rd_data),
    .o_valid      (o_rd_valid)
  );

endmodule
